alu_bist: RTL and testbench
===========================

ALU_BIST -- requirements
Module: alu_bist

Interface
REQ-001 Parameter N_VECTORS, default 16, number of test vectors per run (1..255).
REQ-002 Parameter SEED, default 32'hACE1_2468, initial LFSR state; SHALL be nonzero.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  reset, asynchronous and active-high.
REQ-005 start  input  1  one-cycle pulse that begins a run.
REQ-006 srcA  output  32  operand A driven to the ALU under test.
REQ-007 srcB  output  32  operand B driven to the ALU under test.
REQ-008 opcode  output  3  ALU operation driven to the ALU under test.
REQ-009 result  input  32  ALU result, combinational from srcA/srcB/opcode.
REQ-010 zero_flag  input  1  ALU zero flag, high when result == 0.
REQ-011 busy  output  1  high while a run is in progress.
REQ-012 done  output  1  high from run end until next accepted start or reset.
REQ-013 pass  output  1  valid when done; high iff err_count == 0.
REQ-014 err_count  output  8  mismatching vectors in current/last run, saturates at 255.
REQ-015 first_fail  output  8  index of first mismatching vector; 8'hFF if none.

Function
REQ-016 FSM states: IDLE, DRIVE, CHECK, DONE.
REQ-017 IDLE: start=1 -> DRIVE; err_count cleared, first_fail set to 8'hFF, vector index cleared, LFSR loaded with SEED.
REQ-018 DONE: start=1 -> DRIVE with the same clearing as REQ-017; otherwise DONE is held.
REQ-019 start during DRIVE or CHECK SHALL be ignored.
REQ-020 DRIVE, vector index i: register srcA = lfsr, srcB = {lfsr[15:0], lfsr[31:16]}, opcode = i[2:0]; next state CHECK.
REQ-021 CHECK: sample result/zero_flag and compare both against the expected values computed from the registered srcA/srcB/opcode.
REQ-022 Each vector SHALL take exactly 2 cycles; a run is 2*N_VECTORS cycles from start acceptance to done rising.
REQ-023 Expected result by opcode: 000 A&B; 001 A|B; 010 A+B mod 2^32; 011 32'd0 (reserved); 100 A&~B; 101 A|~B; 110 A-B mod 2^32; 111 32'd1 if signed(A)<signed(B) else 32'd0.
REQ-024 Expected zero_flag SHALL be (expected result == 0).
REQ-025 Mismatch in result or zero_flag counts as one error per vector; err_count increments and saturates at 255; first_fail is captured only while it equals 8'hFF.
REQ-026 LFSR: 32-bit Galois, taps mask 32'h8020_0003, right-shifting; advances once per CHECK cycle.
REQ-027 CHECK with i == N_VECTORS-1 -> DONE; otherwise i increments and next state is DRIVE.
REQ-028 busy SHALL be high exactly in DRIVE and CHECK; done SHALL be high exactly in DONE.
REQ-029 srcA/srcB/opcode SHALL hold their last values in DONE and IDLE.

Reset
REQ-030 On reset: state IDLE, srcA=0, srcB=0, opcode=0, busy=0, done=0, pass=0, err_count=0, first_fail=8'hFF, index=0, LFSR=SEED.
REQ-031 Reset asserted mid-run SHALL abort immediately; no done pulse follows its release.

Structure
REQ-032 ALU opcode constants (ALU_AND..ALU_SLT) and the LFSR tap mask SHALL live in a shared package, also used by alu.
REQ-033 Expected-value computation SHALL be one combinational sub-module alu_ref_model (srcA, srcB, opcode -> exp_result, exp_zero).
REQ-034 The LFSR, index counter, FSM and error logic SHALL live in alu_bist itself.

Verification
REQ-035 SEED=1, N_VECTORS=8, correct alu attached, start pulse -> first DRIVE gives srcA=32'h1, srcB=32'h0001_0000, opcode=0; done rises 16 cycles later; pass=1, err_count=0, first_fail=8'hFF.
REQ-036 Faulty ALU with result[0] stuck at 1, SEED=1, N_VECTORS=8 -> vector 0 (expected 0) fails; first_fail=0, err_count>=1, pass=0.
REQ-037 Faulty ALU with zero_flag stuck at 0, N_VECTORS=255 -> err_count equals the count of vectors with expected result 0, and err_count never wraps.
REQ-038 start pulsed at cycle 3 of a run -> ignored; done still rises exactly 2*N_VECTORS cycles after the first start.
REQ-039 reset asserted during vector 5, then released and start re-pulsed -> outputs match REQ-030 values; the new run repeats the identical vector sequence from SEED.
REQ-040 Two back-to-back runs (start in DONE) -> identical srcA/srcB/opcode sequences; err_count cleared at the second start.

Source files
------------

// File: rtl/alu_bist_pkg.sv
// Shared ALU opcode encodings, LFSR taps and BIST FSM state type.
package alu_bist_pkg;

  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_RSV  = 3'b011;
  localparam logic [2:0] ALU_ANDN = 3'b100;
  localparam logic [2:0] ALU_ORN  = 3'b101;
  localparam logic [2:0] ALU_SUB  = 3'b110;
  localparam logic [2:0] ALU_SLT  = 3'b111;

  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_CHECK,
    ST_DONE
  } bist_state_e;

  // Right-shifting Galois step.
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/alu_bist_ref_model.sv
// Golden ALU: expected result and zero flag for one vector.
module alu_ref_model
  import alu_bist_pkg::*;
(
  input  logic [31:0] srcA,
  input  logic [31:0] srcB,
  input  logic [2:0]  opcode,
  output logic [31:0] exp_result,
  output logic        exp_zero
);

  always_comb begin
    exp_result = '0;
    case (opcode)
      ALU_AND:  exp_result = srcA & srcB;
      ALU_OR:   exp_result = srcA | srcB;
      ALU_ADD:  exp_result = srcA + srcB;
      ALU_RSV:  exp_result = '0;
      ALU_ANDN: exp_result = srcA & ~srcB;
      ALU_ORN:  exp_result = srcA | ~srcB;
      ALU_SUB:  exp_result = srcA - srcB;
      ALU_SLT:  exp_result = ($signed(srcA) < $signed(srcB)) ? 32'd1 : 32'd0;
      default:  exp_result = '0;
    endcase
  end

  assign exp_zero = (exp_result == '0);

endmodule

// File: rtl/alu_bist.sv
// ALU built-in self test: LFSR vectors, two cycles each, error tally.
module alu_bist
  import alu_bist_pkg::*;
#(
  parameter int unsigned N_VECTORS = 16,
  parameter logic [31:0] SEED      = 32'hACE1_2468
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [31:0] srcA,
  output logic [31:0] srcB,
  output logic [2:0]  opcode,
  input  logic [31:0] result,
  input  logic        zero_flag,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [7:0]  err_count,
  output logic [7:0]  first_fail
);

  localparam logic [7:0] LAST_IDX = 8'(N_VECTORS - 1);

  bist_state_e state_q;
  logic [31:0] lfsr_q, srca_q, srcb_q;
  logic [2:0]  op_q;
  logic [7:0]  idx_q, err_q, err_d, ff_q;
  logic        busy_q, done_q, pass_q;
  logic [31:0] exp_result;
  logic        exp_zero, mismatch;

  alu_ref_model u_ref (
    .srcA       (srca_q),
    .srcB       (srcb_q),
    .opcode     (op_q),
    .exp_result (exp_result),
    .exp_zero   (exp_zero)
  );

  assign mismatch = (result != exp_result) || (zero_flag != exp_zero);

  always_comb begin
    err_d = err_q;
    if (mismatch && err_q != 8'hFF)
      err_d = err_q + 8'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      lfsr_q  <= SEED;
      srca_q  <= '0;
      srcb_q  <= '0;
      op_q    <= '0;
      idx_q   <= '0;
      err_q   <= '0;
      ff_q    <= 8'hFF;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_q <= ST_DRIVE;
            lfsr_q  <= SEED;
            idx_q   <= '0;
            err_q   <= '0;
            ff_q    <= 8'hFF;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
          end
        end
        ST_DRIVE: begin
          srca_q  <= lfsr_q;
          srcb_q  <= {lfsr_q[15:0], lfsr_q[31:16]};
          op_q    <= idx_q[2:0];
          state_q <= ST_CHECK;
        end
        ST_CHECK: begin
          lfsr_q <= lfsr_next(lfsr_q);
          err_q  <= err_d;
          if (mismatch && ff_q == 8'hFF)
            ff_q <= idx_q;
          if (idx_q == LAST_IDX) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_d == 8'd0);
          end else begin
            idx_q   <= idx_q + 8'd1;
            state_q <= ST_DRIVE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign srcA       = srca_q;
  assign srcB       = srcb_q;
  assign opcode     = op_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign first_fail = ff_q;

endmodule

// File: tb/tb_alu_bist.sv
// Directed bench: two BIST instances (8 and 255 vectors) on a behavioural ALU.
module tb_alu_bist;
  import alu_bist_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   fault;

  logic        start8, z8, busy8, done8, pass8;
  logic [31:0] a8, b8, r8;
  logic [2:0]  op8;
  logic [7:0]  ec8, ff8;

  logic        start2, z2, busy2, done2, pass2;
  logic [31:0] a2, b2, r2;
  logic [2:0]  op2;
  logic [7:0]  ec2, ff2;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] seqA [0:3][0:7];
  logic [2:0]  seqO [0:3][0:7];
  logic [7:0]  acc_ec, acc_ff;
  logic        acc_done, acc_busy;

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_f(
    input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    logic [31:0] r;
    r = '0;
    case (op)
      ALU_AND:  r = a & b;
      ALU_OR:   r = a | b;
      ALU_ADD:  r = a + b;
      ALU_ANDN: r = a & ~b;
      ALU_ORN:  r = a | ~b;
      ALU_SUB:  r = a - b;
      ALU_SLT:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default:  r = '0;
    endcase
    return r;
  endfunction

  // k-th LFSR state from a seed, taps 8020_0003 right-shifting
  function automatic logic [31:0] lfsr_k(input logic [31:0] seed, input int k);
    logic [31:0] s;
    s = seed;
    for (int j = 0; j < k; j++)
      s = s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
    return s;
  endfunction

  always_comb begin
    r8 = alu_f(a8, b8, op8);
    if (fault == 1) r8[0] = 1'b1;
    z8 = (r8 == '0);
    if (fault == 2) z8 = 1'b0;
    r2 = alu_f(a2, b2, op2);
    if (fault == 1) r2[0] = 1'b1;
    z2 = (r2 == '0);
    if (fault == 2) z2 = 1'b0;
  end

  alu_bist #(.N_VECTORS(8), .SEED(32'h1)) dut (
    .clk(clk), .reset(reset), .start(start8),
    .srcA(a8), .srcB(b8), .opcode(op8),
    .result(r8), .zero_flag(z8),
    .busy(busy8), .done(done8), .pass(pass8),
    .err_count(ec8), .first_fail(ff8)
  );

  alu_bist #(.N_VECTORS(255)) dut255 (
    .clk(clk), .reset(reset), .start(start2),
    .srcA(a2), .srcB(b2), .opcode(op2),
    .result(r2), .zero_flag(z2),
    .busy(busy2), .done(done2), .pass(pass2),
    .err_count(ec2), .first_fail(ff2)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // called just after a negedge; returns cycles from accept edge to done
  task automatic run8(input int id, input bit poke, output int cyc);
    start8 = 1'b1;
    @(posedge clk); #1;
    start8   = 1'b0;
    acc_ec   = ec8;
    acc_ff   = ff8;
    acc_done = done8;
    acc_busy = busy8;
    cyc = 0;
    while (!done8 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc % 2 == 1 && cyc < 16) begin
        seqA[id][cyc/2] = a8;
        seqO[id][cyc/2] = op8;
      end
      start8 = (poke && cyc == 3);
    end
    start8 = 1'b0;
  endtask

  task automatic check_seq(input int id);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("seqA%0d_%0d", id, k), seqA[id][k], lfsr_k(32'h1, k));
      check($sformatf("seqO%0d_%0d", id, k), 32'(seqO[id][k]), 32'(k % 8));
    end
  endtask

  initial begin
    int cyc;
    int exp_cnt;
    int exp_first;
    bit saw_done;
    logic [31:0] s, a, b, r;

    fault  = 0;
    reset  = 1'b1;
    start8 = 1'b0;
    start2 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy8), 32'h0);
    check("rst_done", 32'(done8), 32'h0);
    check("rst_pass", 32'(pass8), 32'h0);
    check("rst_ec", 32'(ec8), 32'h0);
    check("rst_ff", 32'(ff8), 32'hFF);
    check("rst_srcA", a8, 32'h0);
    check("rst_srcB", b8, 32'h0);
    check("rst_op", 32'(op8), 32'h0);
    check("rst_ff255", 32'(ff2), 32'hFF);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // clean run with an ignored start poke mid-run
    run8(0, 1'b1, cyc);
    check("run0_len", 32'(cyc), 32'd16);
    check("v0_srcA", seqA[0][0], 32'h0000_0001);
    check("v0_op", 32'(seqO[0][0]), 32'h0);
    check("v1_srcA", seqA[0][1], 32'h8020_0003);
    check("v2_srcA", seqA[0][2], 32'hC030_0002);
    check("v2_op", 32'(seqO[0][2]), 32'h2);
    check_seq(0);
    check("run0_pass", 32'(pass8), 32'h1);
    check("run0_ec", 32'(ec8), 32'h0);
    check("run0_ff", 32'(ff8), 32'hFF);
    check("run0_busy", 32'(busy8), 32'h0);
    repeat (4) @(negedge clk);
    check("done_hold", 32'(done8), 32'h1);
    check("srcA_hold", a8, lfsr_k(32'h1, 7));
    check("op_hold", 32'(op8), 32'h7);

    // result[0] stuck at 1: vector 0 (1 & 0001_0000 = 0) must fail
    fault = 1;
    @(negedge clk);
    run8(1, 1'b0, cyc);
    check("f1_len", 32'(cyc), 32'd16);
    check("f1_ff", 32'(ff8), 32'h0);
    check("f1_ec_nz", 32'(ec8 != 8'd0), 32'h1);
    check("f1_pass", 32'(pass8), 32'h0);
    check("f1_done", 32'(done8), 32'h1);

    // back-to-back restart from DONE with a good ALU
    fault = 0;
    @(negedge clk);
    run8(2, 1'b0, cyc);
    check("b2b_ec_clr", 32'(acc_ec), 32'h0);
    check("b2b_ff_clr", 32'(acc_ff), 32'hFF);
    check("b2b_done_clr", 32'(acc_done), 32'h0);
    check("b2b_busy", 32'(acc_busy), 32'h1);
    check("b2b_len", 32'(cyc), 32'd16);
    check_seq(2);
    check("b2b_pass", 32'(pass8), 32'h1);

    // reset during vector 5 aborts the run
    @(negedge clk);
    start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    check("v5_srcA", a8, lfsr_k(32'h1, 5));
    reset = 1'b1;
    #1;
    check("abrt_busy", 32'(busy8), 32'h0);
    check("abrt_done", 32'(done8), 32'h0);
    check("abrt_srcA", a8, 32'h0);
    check("abrt_op", 32'(op8), 32'h0);
    check("abrt_ff", 32'(ff8), 32'hFF);
    check("abrt_ec", 32'(ec8), 32'h0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    saw_done = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (done8 || busy8) saw_done = 1'b1;
    end
    check("no_done_after_rst", 32'(saw_done), 32'h0);
    run8(3, 1'b0, cyc);
    check("rerun_len", 32'(cyc), 32'd16);
    check_seq(3);
    check("rerun_pass", 32'(pass8), 32'h1);

    // zero_flag stuck low over 255 vectors from the default seed
    exp_cnt   = 0;
    exp_first = 255;
    s = 32'hACE1_2468;
    for (int i = 0; i < 255; i++) begin
      a = s;
      b = {s[15:0], s[31:16]};
      r = alu_f(a, b, 3'(i));
      if (r == '0) begin
        exp_cnt++;
        if (exp_first == 255) exp_first = i;
      end
      s = s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
    end
    fault = 2;
    @(negedge clk);
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    cyc = 0;
    while (!done2 && cyc < 1000) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("z_len", 32'(cyc), 32'd510);
    check("z_ec", 32'(ec2), 32'(exp_cnt));
    check("z_ff", 32'(ff2), 32'(exp_first));
    check("z_pass", 32'(pass2), 32'h0);
    check("z_rsv_min", 32'(ec2 >= 8'd32), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
